// File: rtl/mac_learning_table.sv
// mac_learning_table: sequential-search MAC table with dst lookup, src learning and round-robin replacement.
module mac_learning_table #(
    parameter int NUM_ENTRIES       = 8,
    parameter int NUM_IQ_BITS       = 3,
    parameter int NUM_OUTPUT_QUEUES = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [47:0]                  dst_mac,
    input  logic [47:0]                  src_mac,
    input  logic [NUM_IQ_BITS-1:0]       src_port,
    input  logic                         eth_done,
    input  logic                         table_clear,
    output logic [NUM_OUTPUT_QUEUES-1:0] dst_ports,
    output logic                         lookup_done,
    output logic                         lookup_hit,
    output logic                         lookup_busy,
    output logic                         lookup_dropped
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ENTRIES - 1);
    typedef enum logic [1:0] {IDLE, SEARCH, RESOLVE} state_t;
    state_t                         state;
    logic [47:0]                    mac_tbl  [NUM_ENTRIES];
    logic [NUM_IQ_BITS-1:0]         port_tbl [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]         valid;
    logic [47:0]                    cap_dst;
    logic [47:0]                    cap_src;
    logic [NUM_IQ_BITS-1:0]         cap_port;
    logic [NUM_IQ_BITS-1:0]         hit_port;
    logic [IDX_W-1:0]               idx;
    logic [IDX_W-1:0]               src_idx;
    logic [IDX_W-1:0]               free_idx;
    logic [IDX_W-1:0]               rr_ptr;
    logic [IDX_W-1:0]               learn_idx;
    logic                           eth_prev;
    logic                           dst_found;
    logic                           src_found;
    logic                           free_found;
    logic                           start;
    logic                           dst_match;
    logic                           src_match;
    logic                           learn_we;
    logic                           fwd;
    logic [NUM_OUTPUT_QUEUES-1:0]   one;
    logic [NUM_OUTPUT_QUEUES-1:0]   flood_mask;
    logic [NUM_OUTPUT_QUEUES-1:0]   fwd_mask;
    always_comb begin
        start      = eth_done && !eth_prev;
        dst_match  = valid[idx] && mac_tbl[idx] == cap_dst;
        src_match  = valid[idx] && mac_tbl[idx] == cap_src;
        learn_we   = state == RESOLVE && !table_clear && !cap_src[40];
        learn_idx  = src_found ? src_idx : free_found ? free_idx : rr_ptr;
        fwd        = dst_found && !cap_dst[40];
        one        = NUM_OUTPUT_QUEUES'(1);
        // an out-of-range ingress port shifts the bit away, leaving a full flood
        flood_mask = ~(one << cap_port);
        fwd_mask   = hit_port == cap_port ? '0 : one << hit_port;
    end
    always_ff @(posedge clk) begin
        if (learn_we) begin
            mac_tbl[learn_idx]  <= cap_src;
            port_tbl[learn_idx] <= cap_port;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            valid          <= '0;
            rr_ptr         <= '0;
            eth_prev       <= 1'b0;
            dst_ports      <= '0;
            lookup_done    <= 1'b0;
            lookup_hit     <= 1'b0;
            lookup_busy    <= 1'b0;
            lookup_dropped <= 1'b0;
            cap_dst        <= '0;
            cap_src        <= '0;
            cap_port       <= '0;
            hit_port       <= '0;
            idx            <= '0;
            src_idx        <= '0;
            free_idx       <= '0;
            dst_found      <= 1'b0;
            src_found      <= 1'b0;
            free_found     <= 1'b0;
        end else begin
            eth_prev       <= eth_done;
            lookup_dropped <= start && state != IDLE;
            lookup_done    <= 1'b0;
            if (table_clear) begin
                valid       <= '0;
                rr_ptr      <= '0;
                state       <= IDLE;
                lookup_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        lookup_busy <= start;
                        if (start) begin
                            cap_dst    <= dst_mac;
                            cap_src    <= src_mac;
                            cap_port   <= src_port;
                            idx        <= '0;
                            dst_found  <= 1'b0;
                            src_found  <= 1'b0;
                            free_found <= 1'b0;
                            state      <= SEARCH;
                        end
                    end
                    SEARCH: begin
                        if (dst_match && !dst_found) begin
                            dst_found <= 1'b1;
                            hit_port  <= port_tbl[idx];
                        end
                        if (src_match && !src_found) begin
                            src_found <= 1'b1;
                            src_idx   <= idx;
                        end
                        if (!valid[idx] && !free_found) begin
                            free_found <= 1'b1;
                            free_idx   <= idx;
                        end
                        idx   <= idx + 1'b1;
                        state <= idx == LAST ? RESOLVE : SEARCH;
                    end
                    RESOLVE: begin
                        lookup_done <= 1'b1;
                        lookup_hit  <= fwd;
                        dst_ports   <= fwd ? fwd_mask : flood_mask;
                        if (!cap_src[40]) begin
                            valid[learn_idx] <= 1'b1;
                            if (!src_found && !free_found)
                                rr_ptr <= rr_ptr + 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mac_learning_table.sv
// tb_mac_learning_table: directed vector table plus hand sequences for drop, clear and reset corners.
module tb_mac_learning_table;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [47:0] dst_mac = '0;
    logic [47:0] src_mac = '0;
    logic [2:0]  src_port = '0;
    logic        eth_done = 1'b0;
    logic        table_clear = 1'b0;
    logic [7:0]  dst_ports;
    logic        lookup_done;
    logic        lookup_hit;
    logic        lookup_busy;
    logic        lookup_dropped;
    int          n_vec = 0;
    int          n_err = 0;
    localparam logic [47:0] MC = 48'h0100_0000_00AA;
    typedef struct {
        logic [47:0] dst;
        logic [47:0] src;
        logic [2:0]  port;
        logic        hit;
        logic [7:0]  ports;
    } vec_t;
    vec_t vecs [20];
    mac_learning_table dut (
        .clk(clk), .reset(reset), .dst_mac(dst_mac), .src_mac(src_mac),
        .src_port(src_port), .eth_done(eth_done), .table_clear(table_clear),
        .dst_ports(dst_ports), .lookup_done(lookup_done), .lookup_hit(lookup_hit),
        .lookup_busy(lookup_busy), .lookup_dropped(lookup_dropped)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic do_lookup(input logic [47:0] d, input logic [47:0] s, input logic [2:0] p,
                             output int lat);
        dst_mac = d;
        src_mac = s;
        src_port = p;
        eth_done = 1'b1;
        @(posedge clk); #1;
        chk("busy_at_capture", 64'(lookup_busy), 64'd1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (lookup_done) begin
                lat = k;
                break;
            end
        end
        eth_done = 1'b0;
    endtask
    task automatic lookup_chk(input string name, input logic [47:0] d, input logic [47:0] s,
                              input logic [2:0] p, input logic eh, input logic [7:0] ep);
        int lat;
        do_lookup(d, s, p, lat);
        chk({name, "_latency"}, 64'(lat), 64'd9);
        chk({name, "_hit"}, 64'(lookup_hit), 64'(eh));
        chk({name, "_ports"}, 64'(dst_ports), 64'(ep));
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, 64'(lookup_done), 64'd0);
        chk({name, "_busy_off"}, 64'(lookup_busy), 64'd0);
    endtask
    initial begin
        int ndone;
        int kdone;
        logic h_at;
        logic [7:0] p_at;
        vecs[0]  = '{48'h2, 48'h1, 3'd1, 1'b0, 8'hFD};
        vecs[1]  = '{48'h1, 48'h2, 3'd4, 1'b1, 8'h02};
        vecs[2]  = '{48'h1, 48'h1, 3'd1, 1'b1, 8'h00};
        vecs[3]  = '{48'hFFFF_FFFF_FFFF, 48'h3, 3'd0, 1'b0, 8'hFE};
        vecs[4]  = '{48'h2, 48'h3, 3'd0, 1'b1, 8'h10};
        vecs[5]  = '{48'h3, 48'h2, 3'd4, 1'b1, 8'h01};
        vecs[6]  = '{48'h4, 48'h5, 3'd7, 1'b0, 8'h7F};
        vecs[7]  = '{48'h5, 48'h4, 3'd2, 1'b1, 8'h80};
        vecs[8]  = '{48'h4, 48'h6, 3'd2, 1'b1, 8'h00};
        vecs[9]  = '{48'h7, 48'h7, 3'd3, 1'b0, 8'hF7};
        vecs[10] = '{48'h7, 48'h7, 3'd3, 1'b1, 8'h00};
        vecs[11] = '{48'h8, 48'h0100_0000_0008, 3'd5, 1'b0, 8'hDF};
        vecs[12] = '{48'h0100_0000_0008, 48'h8, 3'd6, 1'b0, 8'hBF};
        vecs[13] = '{48'h8, 48'h9, 3'd1, 1'b1, 8'h40};
        vecs[14] = '{48'h1, MC, 3'd0, 1'b0, 8'hFE};
        vecs[15] = '{48'h9, MC, 3'd0, 1'b1, 8'h02};
        vecs[16] = '{48'h2, 48'hA, 3'd3, 1'b1, 8'h10};
        vecs[17] = '{48'h2, MC, 3'd0, 1'b0, 8'hFE};
        vecs[18] = '{48'h3, MC, 3'd5, 1'b1, 8'h01};
        vecs[19] = '{48'hA, MC, 3'd0, 1'b1, 8'h08};
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_ports", 64'(dst_ports), 64'd0);
        chk("rst_done", 64'(lookup_done), 64'd0);
        chk("rst_hit", 64'(lookup_hit), 64'd0);
        chk("rst_busy", 64'(lookup_busy), 64'd0);
        chk("rst_dropped", 64'(lookup_dropped), 64'd0);
        for (int i = 0; i < 20; i++)
            lookup_chk($sformatf("v%0d", i), vecs[i].dst, vecs[i].src, vecs[i].port,
                       vecs[i].hit, vecs[i].ports);
        // eth_done falls after capture and rises again while searching
        dst_mac = 48'h3; src_mac = MC; src_port = 3'd2; eth_done = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 eth_done = 1'b0;
        @(posedge clk); #1 eth_done = 1'b1;
        @(posedge clk); #1;
        chk("drop_pulse", 64'(lookup_dropped), 64'd1);
        @(posedge clk); #1;
        chk("drop_pulse_end", 64'(lookup_dropped), 64'd0);
        ndone = 0; kdone = 0; h_at = 1'b0; p_at = '0;
        for (int k = 5; k <= 25; k++) begin
            @(posedge clk); #1;
            if (lookup_done) begin
                ndone++;
                kdone = k;
                h_at = lookup_hit;
                p_at = dst_ports;
            end
        end
        chk("drop_done_count", 64'(ndone), 64'd1);
        chk("drop_done_edge", 64'(kdone), 64'd9);
        chk("drop_hit", 64'(h_at), 64'd1);
        chk("drop_ports", 64'(p_at), 64'h01);
        eth_done = 1'b0;
        @(posedge clk); #1;
        // table_clear three edges into the search
        dst_mac = 48'h3; src_mac = 48'hB; src_port = 3'd1; eth_done = 1'b1;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1 table_clear = 1'b1;
        @(posedge clk); #1 table_clear = 1'b0;
        chk("clr_busy", 64'(lookup_busy), 64'd0);
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (lookup_done) ndone++;
        end
        chk("clr_no_done", 64'(ndone), 64'd0);
        eth_done = 1'b0;
        @(posedge clk); #1;
        lookup_chk("clr_miss", 48'h3, MC, 3'd2, 1'b0, 8'hFB);
        lookup_chk("clr_src_not_learned", 48'hB, MC, 3'd0, 1'b0, 8'hFE);
        // async reset at search index 4
        lookup_chk("pre_rst_learn", 48'h3, 48'hC, 3'd5, 1'b0, 8'hDF);
        dst_mac = 48'hC; src_mac = MC; src_port = 3'd1; eth_done = 1'b1;
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_busy", 64'(lookup_busy), 64'd1);
        reset = 1'b1; eth_done = 1'b0;
        #1;
        chk("mid_rst_ports", 64'(dst_ports), 64'd0);
        chk("mid_rst_busy", 64'(lookup_busy), 64'd0);
        chk("mid_rst_hit", 64'(lookup_hit), 64'd0);
        chk("mid_rst_done", 64'(lookup_done), 64'd0);
        chk("mid_rst_dropped", 64'(lookup_dropped), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (lookup_done) ndone++;
        end
        chk("post_rst_no_done", 64'(ndone), 64'd0);
        lookup_chk("post_rst_miss", 48'hC, MC, 3'd1, 1'b0, 8'hFD);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
